// File: rtl/minmax_pkg.sv
// Shared constants and helpers for the sliding-window min/max tracker.
package minmax_pkg;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 32;

  // Width of a counter that must hold values 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/minmax_reduce.sv
// Occupancy-masked min/max over a window of samples; empty window yields zeros.
module minmax_reduce
  import minmax_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 1
) (
  input  logic [DEPTH-1:0][WIDTH-1:0] vals,
  input  logic [DEPTH-1:0]            occ,
  output logic [WIDTH-1:0]            min_o,
  output logic [WIDTH-1:0]            max_o
);

  function automatic logic lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) < $signed(b);
    else             return a < b;
  endfunction

  logic any_seen;

  // The first occupied entry seeds both results so empty slots never leak in.
  always_comb begin
    min_o    = '0;
    max_o    = '0;
    any_seen = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i]) begin
        if (!any_seen || lt(vals[i], min_o)) min_o = vals[i];
        if (!any_seen || lt(max_o, vals[i])) max_o = vals[i];
        any_seen = 1'b1;
      end
    end
  end

endmodule

// File: rtl/minmax_window.sv
// Sliding-window min/max tracker: shift-register window with occupancy bits,
// reduction over next-state window so a new sample is visible one edge later.
module minmax_window
  import minmax_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 4,
  parameter int SIGNED = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [WIDTH-1:0]          num,
  output logic [WIDTH-1:0]          min,
  output logic [WIDTH-1:0]          max,
  output logic                      out_valid,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_chk
    $error("minmax_window: DEPTH out of legal range");
  end

  logic [DEPTH-1:0][WIDTH-1:0] win_q, win_d;
  logic [DEPTH-1:0]            occ_q, occ_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [WIDTH-1:0]            min_q, max_q, red_min, red_max;
  logic                        vld_q;

  // Entry 0 is the newest sample; a clear empties before the new sample lands.
  always_comb begin
    win_d = win_q;
    occ_d = occ_q;
    cnt_d = cnt_q;
    if (clear) begin
      occ_d = '0;
      cnt_d = '0;
    end
    if (in_valid) begin
      win_d = {win_q[DEPTH-2:0], num};
      occ_d = {occ_d[DEPTH-2:0], 1'b1};
      if (cnt_d != CW'(DEPTH)) cnt_d = cnt_d + 1'b1;
    end
  end

  minmax_reduce #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .SIGNED (SIGNED)
  ) u_reduce (
    .vals  (win_d),
    .occ   (occ_d),
    .min_o (red_min),
    .max_o (red_max)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= '0;
      occ_q <= '0;
      cnt_q <= '0;
      min_q <= '0;
      max_q <= '0;
      vld_q <= 1'b0;
    end else begin
      win_q <= win_d;
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      min_q <= red_min;
      max_q <= red_max;
      vld_q <= |occ_d;
    end
  end

  assign min       = min_q;
  assign max       = max_q;
  assign out_valid = vld_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_minmax_window.sv
// Bench for minmax_window: spec vector table plus randomized stream against a
// queue-based window model; signed and unsigned instances share stimulus.
module tb_minmax_window;
  logic        clk = 1'b0;
  logic        rst, clear, in_valid;
  logic [31:0] num;
  logic [31:0] s_min, s_max, u_min, u_max;
  logic        s_vld, u_vld;
  logic [2:0]  s_cnt, u_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  minmax_window #(.WIDTH(32), .DEPTH(4), .SIGNED(1)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .num(num),
    .min(s_min), .max(s_max), .out_valid(s_vld), .count(s_cnt));

  minmax_window #(.WIDTH(32), .DEPTH(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .num(num),
    .min(u_min), .max(u_max), .out_valid(u_vld), .count(u_cnt));

  typedef struct {
    bit          r, c, v;
    logic [31:0] n;
    logic [31:0] smin, smax, umin, umax;
    int          cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] smin, smax, umin, umax;
    int          cnt;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  logic [31:0] mw[$];

  function automatic void add(input bit r, c, v, input logic [31:0] n,
                              input logic [31:0] smin, smax, umin, umax,
                              input int cnt);
    vec_t t;
    t.r = r; t.c = c; t.v = v; t.n = n;
    t.smin = smin; t.smax = smax; t.umin = umin; t.umax = umax; t.cnt = cnt;
    tbl.push_back(t);
  endfunction

  // Reference window: plain queue of samples, oldest first.
  function automatic void mdl_update(input bit r, c, v, input logic [31:0] n);
    if (r) begin
      mw.delete();
    end else begin
      if (c) mw.delete();
      if (v) begin
        mw.push_back(n);
        if (mw.size() > 4) void'(mw.pop_front());
      end
    end
  endfunction

  function automatic void mdl_expect(output exp_t e);
    e.smin = 0; e.smax = 0; e.umin = 0; e.umax = 0;
    e.cnt  = mw.size();
    foreach (mw[i]) begin
      if (i == 0) begin
        e.smin = mw[i]; e.smax = mw[i]; e.umin = mw[i]; e.umax = mw[i];
      end else begin
        if ($signed(mw[i]) < $signed(e.smin)) e.smin = mw[i];
        if ($signed(mw[i]) > $signed(e.smax)) e.smax = mw[i];
        if (mw[i] < e.umin) e.umin = mw[i];
        if (mw[i] > e.umax) e.umax = mw[i];
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; expectation is pushed with the stimulus and popped after the edge.
  task automatic step(input string name, input bit r, c, v, input logic [31:0] n,
                      input bit use_tbl, input vec_t t);
    exp_t e, got;
    @(negedge clk);
    rst = r; clear = c; in_valid = v; num = n;
    mdl_update(r, c, v, n);
    mdl_expect(e);
    if (use_tbl) begin
      e.smin = t.smin; e.smax = t.smax; e.umin = t.umin; e.umax = t.umax; e.cnt = t.cnt;
    end
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({got.name, " s_min"}, s_min, got.smin);
    chk({got.name, " s_max"}, s_max, got.smax);
    chk({got.name, " s_cnt"}, {29'd0, s_cnt}, got.cnt);
    chk({got.name, " s_vld"}, {31'd0, s_vld}, {31'd0, got.cnt != 0});
    chk({got.name, " u_min"}, u_min, got.umin);
    chk({got.name, " u_max"}, u_max, got.umax);
    chk({got.name, " u_cnt"}, {29'd0, u_cnt}, got.cnt);
  endtask

  initial begin
    vec_t dummy;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; num = '0;
    dummy = '{default: 0};

    // reset, idle on empty window, then 2,1,3,0
    add(1,0,0,0,  0,0,0,0,0);
    add(0,0,0,0,  0,0,0,0,0);
    add(0,0,1,2,  2,2,2,2,1);
    add(0,0,1,1,  1,2,1,2,2);
    add(0,0,1,3,  1,3,1,3,3);
    add(0,0,1,0,  0,3,0,3,4);
    // clear alone, then clear with a sample
    add(0,1,0,0,  0,0,0,0,0);
    add(0,1,1,7,  7,7,7,7,1);
    // eviction stream 5,9,1,7,4,6,8
    add(1,0,0,0,  0,0,0,0,0);
    add(0,0,1,5,  5,5,5,5,1);
    add(0,0,1,9,  5,9,5,9,2);
    add(0,0,1,1,  1,9,1,9,3);
    add(0,0,1,7,  1,9,1,9,4);
    add(0,0,1,4,  1,9,1,9,4);
    add(0,0,1,6,  1,7,1,7,4);
    add(0,0,1,8,  4,8,4,8,4);
    // signed vs unsigned: -1, 3
    add(1,0,0,0,  0,0,0,0,0);
    add(0,0,1,32'hFFFFFFFF, 32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,1);
    add(0,0,1,3,  32'hFFFFFFFF,3,3,32'hFFFFFFFF,2);
    // hold while idle, reset beats a valid sample, then fresh start
    add(1,0,0,0,  0,0,0,0,0);
    add(0,0,1,4,  4,4,4,4,1);
    add(0,0,1,8,  4,8,4,8,2);
    add(0,0,0,0,  4,8,4,8,2);
    add(0,0,0,0,  4,8,4,8,2);
    add(0,0,0,0,  4,8,4,8,2);
    add(1,1,1,1,  0,0,0,0,0);
    add(0,0,1,6,  6,6,6,6,1);

    foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].r, tbl[i].c, tbl[i].v, tbl[i].n, 1'b1, tbl[i]);

    // randomized stream against the model, values biased toward sign boundaries
    for (int i = 0; i < 300; i++) begin
      logic [31:0] n;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: n = 32'h8000_0000;
        1: n = 32'h7FFF_FFFF;
        2: n = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        default: n = 32'($urandom_range(0, 40));
      endcase
      step($sformatf("rnd%0d", i), $urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0, n, 1'b0, dummy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/minmax_window.md
MINMAX_WINDOW -- requirements
Module: minmax_window

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning sample width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning window length in samples (legal range 2..32).
REQ-003 The module SHALL have parameter SIGNED, default 1, meaning 1 = two's-complement compare, 0 = unsigned compare.
REQ-004 Port: clk  input  1  single system clock, all logic on rising edge.
REQ-005 Port: rst  input  1  reset, synchronous, active-high.
REQ-006 Port: clear  input  1  synchronous window flush.
REQ-007 Port: in_valid  input  1  num carries a sample this cycle.
REQ-008 Port: num  input  WIDTH  sample value.
REQ-009 Port: min  output  WIDTH  minimum over current window, registered.
REQ-010 Port: max  output  WIDTH  maximum over current window, registered.
REQ-011 Port: out_valid  output  1  window holds at least one sample, registered.
REQ-012 Port: count  output  $clog2(DEPTH+1)  number of samples in window, registered, saturates at DEPTH.

Function
REQ-013 A sample SHALL be accepted on every rising clk edge where in_valid=1 and rst=0; no ready/backpressure exists.
REQ-014 Window SHALL hold the last count accepted samples, oldest evicted when a sample is accepted at count=DEPTH.
REQ-015 min/max/count/out_valid SHALL reflect the window including the sample accepted at edge k, visible from edge k onward (latency 1 cycle, no idle cycle needed between samples).
REQ-016 Back-to-back samples on consecutive cycles SHALL each be folded in; no sample SHALL be dropped.
REQ-017 With in_valid=0 and clear=0, all outputs and window contents SHALL hold.
REQ-018 Only occupied entries SHALL participate in the reduction; unoccupied entry contents SHALL never affect min/max.
REQ-019 Compare SHALL be signed when SIGNED=1, unsigned when SIGNED=0; equal values SHALL produce that value, no width extension.
REQ-020 Empty window (count=0): min=0, max=0, out_valid=0.
REQ-021 clear=1 without in_valid SHALL empty the window at that edge: count=0, out_valid=0, min=max=0.
REQ-022 clear=1 with in_valid=1 SHALL leave the window holding only num: count=1, min=max=num, out_valid=1.
REQ-023 count SHALL increment by 1 per accepted sample until DEPTH, then stay at DEPTH (no wrap).
REQ-024 Window storage SHALL be a shift register with per-entry occupancy bits; reduction SHALL be combinational over storage plus incoming sample, result registered.

Reset
REQ-025 rst=1 at an edge SHALL force count=0, out_valid=0, min=0, max=0, all occupancy bits 0, regardless of clear/in_valid.
REQ-026 rst SHALL take priority over clear and in_valid; a sample presented with rst=1 SHALL be discarded.
REQ-027 rst asserted mid-stream SHALL fully discard prior history; first sample after release SHALL yield min=max=that sample.

Structure
REQ-028 Package minmax_pkg SHALL hold the count-width function and the DEPTH legal-range constants.
REQ-029 One sub-module minmax_reduce SHALL implement the parameterised occupancy-masked min/max reduction (WIDTH, DEPTH, SIGNED); minmax_window instantiates it once.

Verification (WIDTH=32, DEPTH=4 unless stated)
REQ-030 SIGNED=1, reset then num 2,1,3,0 on four consecutive valid cycles -> (min,max,count) after each edge: (2,2,1),(1,2,2),(1,3,3),(0,3,4).
REQ-031 Stream 5,9,1,7,4,6,8 back-to-back -> after 5th: min=1,max=9; after 6th: min=1,max=7; after 7th: min=4,max=8; count stays 4.
REQ-032 Stream -1,3: SIGNED=1 -> min=-1,max=3; SIGNED=0 -> min=3,max=32'hFFFFFFFF.
REQ-033 Window full of 2,1,3,0 then clear alone -> count=0,out_valid=0,min=max=0; then clear+in_valid with num=7 -> count=1,min=max=7.
REQ-034 Samples 4,8, then in_valid low 3 cycles -> min=4,max=8,count=2 held; then rst during valid num=1 -> all outputs 0; next valid num=6 -> min=max=6,count=1.
